spi_slave: RTL
==============

# spi_slave

SPI responder for SPI mode 0 (CPOL=0, CPHA=0), MSB first, with a fixed word length. It is the far end of the SPI master link in the project. It runs entirely in the system `clk` domain: it oversamples the external `sclk`, `ss` and `mosi` through synchronizers and detects edges on the synchronized signals. It exposes a one-word transmit holding buffer with a valid/ready handshake and a one-cycle receive strobe to the FPGA fabric.

## Interface
- `DATA_WIDTH`, default 8: bits per word; must be ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flops on `sclk`, `ss` and `mosi`; must be ≥ 2.

- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock from the master; asynchronous to `clk`.
- `ss` in 1: slave select, active low; asynchronous to `clk`.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master; driven 0 while `ss` is high.
- `tx_data` in DATA_WIDTH: next word to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding buffer is empty; a word is accepted on `tx_valid && tx_ready`.
- `rx_data` out DATA_WIDTH: last complete received word; holds until the next word completes.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `busy` out 1: high while the synchronized `ss` is low.
- `tx_underrun` out 1: one-cycle pulse when a word starts with the holding buffer empty.

## Operation
- **Synchronizers:** `sclk_s`, `ss_s` and `mosi_s` are the outputs of the SYNC_STAGES-deep synchronizers. One further register of `sclk_s` and `ss_s` provides edge detection:
  - `rise` = `sclk_s` && !prev
  - `fall` = !`sclk_s` && prev
  - `sel` = `ss_s` falling
  - `desel` = `ss_s` rising
- **Holding buffer:** one word plus a `hold_full` flag. `tx_ready` = !`hold_full`, a registered value. A handshake sets `hold_full` and captures `tx_data`. `hold_full` clears when the word moves into the shift register. If both happen in the same cycle, the transfer wins; the handshake cannot fire because `tx_ready` was 0.
- **FSM states:** IDLE, SHIFT.
- **IDLE:**
  - `busy`=0, `miso`=0, `bit_cnt`=0.
  - On `sel`: go to SHIFT and load `tx_shift`. The load takes the holding buffer if `hold_full`; otherwise it takes all zeros and pulses `tx_underrun`.
- **SHIFT:**
  - `busy`=1; `miso` = `tx_shift[DATA_WIDTH-1]`.
  - **On `rise`:**
    - `rx_shift` <= {`rx_shift[DATA_WIDTH-2:0]`, `mosi_s`}.
    - If `bit_cnt`==DATA_WIDTH-1: `rx_data` <= {`rx_shift[DATA_WIDTH-2:0]`, `mosi_s`}, `rx_valid` <= 1, `bit_cnt` <= 0 (wrap).
    - Otherwise: `bit_cnt` <= `bit_cnt`+1.
  - **On `fall`:**
    - If `bit_cnt` != 0: `tx_shift` <= `tx_shift` << 1.
    - If `bit_cnt`==0 (word boundary): reload `tx_shift` from the holding buffer, or from zeros with a `tx_underrun` pulse. This supports back-to-back words within one `ss` assertion.
  - **On `desel`:** return to IDLE. A partial word is discarded with no `rx_valid`; `bit_cnt` and `rx_shift` clear. A word already loaded into `tx_shift` is lost; the holding buffer is kept.
- **Precedence:**
  - `reset` overrides everything.
  - `desel` overrides `rise`/`fall` in the same cycle.
  - `sel` and `rise` cannot coincide legally; if they do, `sel` wins and `rise` is ignored.
- **Widths:** `bit_cnt` is $clog2(DATA_WIDTH) bits wide and is compared against DATA_WIDTH-1 only.
- **Reset values:**
  - `miso` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `busy` 0, `tx_underrun` 0.
  - State IDLE, `hold_full` 0, all shift registers 0.

## Timing
- Input-to-detect latency is SYNC_STAGES+1 `clk` cycles from a pin transition to the cycle in which `rise`/`fall`/`sel`/`desel` is high.
- `rx_valid` is high in the cycle after the `rise` of the last bit, i.e. SYNC_STAGES+2 cycles after the last `sclk` rising edge at the pin. It lasts exactly one cycle.
- `miso` changes one cycle after `fall` or `sel`.
- The master must keep `sclk` high and low each ≥ SYNC_STAGES+3 `clk` cycles. `ss` setup to the first `sclk` rise must be ≥ SYNC_STAGES+3 cycles, so `miso` is valid before the first sample.
- `tx_ready` rises one cycle after the transfer into `tx_shift`.
- `tx_underrun` is a one-cycle pulse coincident with the load.
- `busy` follows `ss_s` with one cycle of latency.

## Test plan
- **Single word:** load `tx_data`=0xA5 while idle; the master sends 0x3C with 8 clocks. Required: `miso` bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C with one `rx_valid` pulse; `tx_ready` returns to 1; `busy` high only during `ss` low.
- **Back-to-back:** preload 0x11, then supply 0x22 after the first load; the master sends 0xF0, 0x0F in one `ss` frame. Required: two `rx_valid` pulses with 0xF0 then 0x0F; `miso` carries 0x11 then 0x22; no `tx_underrun`.
- **Underrun:** no word loaded, master transfers 0xFF. Required: `tx_underrun` pulses once at select; `miso` stays 0 for all 8 bits; `rx_data`=0xFF.
- **Abort:** `ss` deasserted after 5 clocks of 0xAA, then a new full transfer of 0x55. Required: no `rx_valid` for the partial word; next `rx_data`=0x55 (not shifted by stale bits).
- **Handshake:** hold `tx_valid` high with 0x01 then 0x02 across a transfer. Required: 0x01 accepted immediately; `tx_ready`=0 until the load at select; 0x02 accepted the cycle after.
- **Reset mid-transfer:** assert `reset` for 1 cycle after 3 `sclk` clocks. Required: all outputs return to reset values the next cycle; the FSM stays IDLE until a new `ss` falling edge.

Source files
------------

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder with synchronized inputs, one-word transmit buffer and receive strobe
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [CW-1:0]          bit_cnt;

    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;
    logic                   sel;
    logic                   desel;
    logic                   load_req;
    logic [DATA_WIDTH-1:0]  load_word;
    logic [DATA_WIDTH-1:0]  tx_shifted;
    logic [DATA_WIDTH-1:0]  rx_next;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign rise  = sclk_s & ~sclk_d;
    assign fall  = ~sclk_s & sclk_d;
    assign sel   = ~ss_s & ss_d;
    assign desel = ss_s & ~ss_d;

    // A word enters tx_shift at select and at every word boundary inside a
    // frame; deselect suppresses a coincident boundary reload.
    assign load_req = ((state == IDLE) && sel) ||
                      ((state == SHIFT) && !desel && fall && (bit_cnt == '0));
    assign load_word  = hold_full ? hold_data : '0;
    assign tx_shifted = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign rx_next    = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    assign tx_ready = ~hold_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizers clear to 0 so a select held low across reset
            // produces no falling edge; only a fresh ss assertion starts a frame.
            sclk_sync   <= '0;
            ss_sync     <= '0;
            mosi_sync   <= '0;
            sclk_d      <= 1'b0;
            ss_d        <= 1'b0;
            state       <= IDLE;
            hold_full   <= 1'b0;
            hold_data   <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            miso        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync     <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d      <= sclk_s;
            ss_d        <= ss_s;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            if (load_req) begin
                tx_shift <= load_word;
                miso     <= load_word[DATA_WIDTH-1];
                if (hold_full) begin
                    hold_full <= 1'b0;
                end else begin
                    tx_underrun <= 1'b1;
                end
            end

            // Cannot collide with a buffer-draining load: that needs hold_full.
            if (tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end

            case (state)
                IDLE: begin
                    if (sel) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (desel) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        miso     <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                    end else begin
                        if (rise) begin
                            rx_shift <= rx_next;
                            if (bit_cnt == LAST_BIT) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        if (fall && (bit_cnt != '0)) begin
                            tx_shift <= tx_shifted;
                            miso     <= tx_shifted[DATA_WIDTH-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
